// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial word loader: default word length,
// matching bit-counter width and the controller state encoding.
package serial_loader_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_loader.sv
// Serial word loader: accepts a parallel word with a direction request and
// streams it one bit per cycle into a downstream shift register, so that
// after WIDTH load cycles the downstream register holds the captured word.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_dir,
    output logic             data,
    output logic             load,
    output logic             direction,
    output logic             done
);

    // Counter width follows WIDTH; a 1-bit word still needs a 1-bit counter.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             dir_reg, dir_next;
    logic [CNT_W-1:0] bit_idx;

    // State, counter and captured word/direction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            word_reg  <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            dir_reg   <= dir_next;
        end
    end

    // Next-state logic: capture only in IDLE, walk the counter in SHIFT,
    // and leave SHIFT on the last bit instead of letting the counter wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        dir_next   = dir_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    word_next  = in_word;
                    dir_next   = in_dir;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs: the serial bit is picked by index from the held word
    // (LSB first for right shifts, MSB first for left shifts).
    always_comb begin
        in_ready = 1'b0;
        load     = 1'b0;
        done     = 1'b0;
        data     = 1'b0;
        bit_idx  = dir_reg ? (LAST_BIT - cnt_reg) : cnt_reg;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                load = 1'b1;
                data = word_reg[bit_idx];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Direction select follows the captured request and holds between words.
    assign direction = dir_reg;

endmodule

// File: tb/tb_serial_loader.sv
// Directed-plus-random bench for serial_loader with a downstream shift
// register model and a bit-order reference computed from the word itself.
module tb_serial_loader;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_word;
    logic         in_dir;
    logic         data;
    logic         load;
    logic         direction;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int load_cnt = 0;
    logic [W-1:0] shifter = '0;

    serial_loader #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_dir    (in_dir),
        .data      (data),
        .load      (load),
        .direction (direction),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift register: dir 0 enters at the MSB, dir 1 at the LSB.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            load_cnt <= load_cnt + 1;
            if (direction)
                shifter <= {shifter[W-2:0], data};
            else
                shifter <= {data, shifter[W-1:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference bit for position k: LSB first for dir 0, MSB first for dir 1.
    function automatic logic ref_bit(input logic [W-1:0] w, input logic d, input int k);
        int pos;
        pos = d ? (W - 1 - k) : k;
        return logic'((w >> pos) & 1);
    endfunction

    // Present one word from IDLE and check every cycle through DONE.
    // hold=1 keeps in_valid high with a junk word/direction while busy.
    task automatic send_word(input logic [W-1:0] w, input logic d, input logic hold,
                             input logic [W-1:0] junk, output int hs_cyc);
        logic seq_ok;
        chk("idle_ready", in_ready, 1);
        chk("idle_load", load, 0);
        in_valid = 1'b1;
        in_word  = w;
        in_dir   = d;
        hs_cyc   = cyc;
        step();
        load_cnt = 0;
        in_valid = hold;
        in_word  = junk;
        in_dir   = ~d;
        seq_ok   = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (load !== 1'b1 || in_ready !== 1'b0 || direction !== d ||
                data !== ref_bit(w, d, k) || done !== 1'b0)
                seq_ok = 1'b0;
            step();
        end
        chk("shift_sequence", seq_ok, 1);
        chk("done_pulse", done, 1);
        chk("done_load", load, 0);
        chk("done_ready", in_ready, 0);
        chk("done_data", data, 0);
        chk("done_dir_hold", direction, d);
        chk("shifter_word", shifter, w);
        chk("load_count", load_cnt, W);
        step();
        chk("after_done", done, 0);
    endtask

    initial begin
        int hs1, hs2, hs_dummy;
        logic ok;
        logic [W-1:0] rw;
        logic rd;

        // Reset with in_valid high: nothing may be captured.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_word  = 16'hBEEF;
        in_dir   = 1'b1;
        step();
        chk("rst_ready", in_ready, 1);
        chk("rst_load", load, 0);
        chk("rst_data", data, 0);
        chk("rst_dir", direction, 0);
        chk("rst_done", done, 0);
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_rst_load", load, 0);
        chk("post_rst_ready", in_ready, 1);

        // Reference word, both directions.
        send_word(16'hA5C3, 1'b0, 1'b0, 16'h0000, hs1);
        send_word(16'hA5C3, 1'b1, 1'b0, 16'h0000, hs1);

        // Inputs ignored while busy; the second word waits for IDLE.
        send_word(16'h1234, 1'b0, 1'b1, 16'hFFFF, hs1);
        send_word(16'hFFFF, 1'b1, 1'b0, 16'h0000, hs2);

        // Back-to-back with in_valid continuously high.
        send_word(16'h0001, 1'b0, 1'b1, 16'h8000, hs1);
        send_word(16'h8000, 1'b1, 1'b0, 16'h0000, hs2);
        chk("handshake_spacing", hs2 - hs1, W + 2);

        // Abort at the 6th load cycle with a one-cycle reset.
        in_valid = 1'b1;
        in_word  = 16'h5A5A;
        in_dir   = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("abort_6th_load", load, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_load", load, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_dir", direction, 0);
        ok = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            if (done !== 1'b0 || load !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
            step();
        end
        chk("abort_no_resume", ok, 1);

        // Randomized words, directions and idle gaps.
        for (int n = 0; n < 20; n++) begin
            rw = W'($urandom);
            rd = 1'($urandom_range(0, 1));
            send_word(rw, rd, 1'($urandom_range(0, 1)), W'($urandom), hs_dummy);
            in_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
